// File: rtl/mem_port_arbiter_if.sv
// Bundle of the signals around the shared memory port.
//   Fetch side : if_req, if_addr  -> if_rdata, if_valid
//   Data side  : mem_req, mem_we, mem_addr, mem_wdata -> mem_rdata, mem_valid
//   Memory side: ram_req, ram_we, ram_addr, ram_wdata -> ram_rdata, ram_ack
//   Status     : bus_err (sticky timeout), stage enables pc_en/IF/ID/EX/Mem
// master modport = arbiter view, slave modport = pipeline/memory view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_valid;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_valid;

  logic              ram_req;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic              ram_ack;

  logic              bus_err;
  logic              pc_en;
  logic              IF;
  logic              ID;
  logic              EX;
  logic              Mem;

  modport master (
    input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata,
           ram_rdata, ram_ack,
    output if_rdata, if_valid, mem_rdata, mem_valid,
           ram_req, ram_we, ram_addr, ram_wdata,
           bus_err, pc_en, IF, ID, EX, Mem
  );

  modport slave (
    output if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata,
           ram_rdata, ram_ack,
    input  if_rdata, if_valid, mem_rdata, mem_valid,
           ram_req, ram_we, ram_addr, ram_wdata,
           bus_err, pc_en, IF, ID, EX, Mem
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbiter for the single-ported unified memory shared by instruction fetch
// and the Mem stage. Each access is a req/ack handshake with variable memory
// latency and a timeout; data accesses win over fetches.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - mem_port_arbiter_if.master: fetch/data request ports, memory
//          port, sticky bus_err and the pipeline stage enables.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  mem_port_arbiter_if.master    bus
);

  typedef enum logic [1:0] {IDLE, D_ACC, I_ACC, DONE} state_t;

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  state_t            state_q;
  logic              ram_req_q;
  logic              ram_we_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [DATA_W-1:0] ram_wdata_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] mem_rdata_q;
  logic              if_valid_q;
  logic              mem_valid_q;
  logic              bus_err_q;
  logic [7:0]        wait_cnt_q;

  logic              finish_d;   // access ends this cycle (ack or timeout)
  logic [DATA_W-1:0] cap_data_d; // value returned to the requester
  logic              data_stall;
  logic              fetch_stall;

  // An ack in the same cycle as the timeout wins: the access completes normally.
  assign finish_d   = bus.ram_ack || (wait_cnt_q == TIMEOUT_C);
  assign cap_data_d = bus.ram_ack ? bus.ram_rdata : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ram_req_q   <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
      if_valid_q  <= 1'b0;
      mem_valid_q <= 1'b0;
      bus_err_q   <= 1'b0;
      wait_cnt_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          wait_cnt_q <= '0;
          if (bus.mem_req) begin
            ram_addr_q  <= bus.mem_addr;
            ram_we_q    <= bus.mem_we;
            ram_wdata_q <= bus.mem_wdata;
            ram_req_q   <= 1'b1;
            state_q     <= D_ACC;
          end else if (bus.if_req) begin
            ram_addr_q  <= bus.if_addr;
            ram_we_q    <= 1'b0;
            ram_req_q   <= 1'b1;
            state_q     <= I_ACC;
          end
        end

        D_ACC, I_ACC: begin
          if (finish_d) begin
            ram_req_q <= 1'b0;
            ram_we_q  <= 1'b0;
            if (!bus.ram_ack) begin
              bus_err_q <= 1'b1;
            end
            if (state_q == D_ACC) begin
              mem_valid_q <= 1'b1;
              // Stores keep the last load value visible.
              if (!ram_we_q) begin
                mem_rdata_q <= cap_data_d;
              end
            end else begin
              if_valid_q <= 1'b1;
              if_rdata_q <= cap_data_d;
            end
            state_q <= DONE;
          end else begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
          end
        end

        // One dead cycle so a request still held alongside its valid pulse
        // is not granted a second time.
        DONE: begin
          if_valid_q  <= 1'b0;
          mem_valid_q <= 1'b0;
          state_q     <= IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.ram_req   = ram_req_q;
  assign bus.ram_we    = ram_we_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_wdata = ram_wdata_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.if_valid  = if_valid_q;
  assign bus.mem_rdata = mem_rdata_q;
  assign bus.mem_valid = mem_valid_q;
  assign bus.bus_err   = bus_err_q;

  // A pending data access freezes the whole pipe; a pending fetch only
  // holds PC and IF so older instructions keep draining.
  assign data_stall  = bus.mem_req & ~mem_valid_q;
  assign fetch_stall = bus.if_req & ~if_valid_q;

  assign bus.pc_en = ~(data_stall | fetch_stall);
  assign bus.IF    = ~(data_stall | fetch_stall);
  assign bus.ID    = ~data_stall;
  assign bus.EX    = ~data_stall;
  assign bus.Mem   = ~data_stall;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    int          dly;    // ack on the dly-th cycle of ram_req, 0 = never
    bit          is_data;
  } acc_t;

  typedef struct {
    logic [31:0] rdata;
    bit          to;
  } rsp_t;

  acc_t acc_q[$];
  rsp_t exp_if_q[$];
  rsp_t exp_mem_q[$];

  logic [31:0] ref_mem[logic [31:0]];
  logic [31:0] ram_mem[logic [31:0]];
  logic [31:0] last_load;
  bit          berr_exp;

  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    total++;
    bad++;
    $display("FAIL %s at %0t", nm, $time);
  endtask

  function automatic logic [31:0] mem_default(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1234_5678;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : mem_default(a);
  endfunction

  function automatic logic [31:0] ram_rd(input logic [31:0] a);
    return ram_mem.exists(a) ? ram_mem[a] : mem_default(a);
  endfunction

  // An access is acknowledged only if the ack arrives no later than the
  // cycle on which the wait counter reaches TIMEOUT.
  function automatic bit acked(input int d);
    return (d >= 1) && (d <= TO + 1);
  endfunction

  function automatic int rand_dly();
    int r;
    r = int'($urandom_range(0, 9));
    if (r == 0) return 0;
    if (r == 1) return TO + 1;
    return int'($urandom_range(1, TO));
  endfunction

  // ---------------- reference model: expected grants and responses -------
  task automatic push_fetch(input logic [31:0] a, input int d);
    rsp_t r;
    acc_q.push_back('{addr: a, we: 1'b0, wdata: 32'h0, dly: d, is_data: 1'b0});
    r.rdata = acked(d) ? ref_rd(a) : 32'h0;
    r.to    = !acked(d);
    exp_if_q.push_back(r);
  endtask

  task automatic push_data(input logic [31:0] a, input logic we, input logic [31:0] wd, input int d);
    rsp_t r;
    acc_q.push_back('{addr: a, we: we, wdata: wd, dly: d, is_data: 1'b1});
    if (we) begin
      if (acked(d)) ref_mem[a] = wd;
    end else begin
      last_load = acked(d) ? ref_rd(a) : 32'h0;
    end
    r.rdata = last_load;
    r.to    = !acked(d);
    exp_mem_q.push_back(r);
  endtask

  // kind: 0 fetch only, 1 data only, 2 simultaneous, 3 fetch then data one cycle later
  task automatic run_round(input int kind, input logic [31:0] fa, input logic [31:0] da,
                           input logic we, input logic [31:0] wd,
                           input int fd, input int dd, input bit hold);
    bit f_done, d_done, late;
    int cyc;
    late = (kind == 3);
    case (kind)
      0: push_fetch(fa, fd);
      1: push_data(da, we, wd, dd);
      2: begin push_data(da, we, wd, dd); push_fetch(fa, fd); end
      default: begin push_fetch(fa, fd); push_data(da, we, wd, dd); end
    endcase
    @(negedge clk);
    f_done = (kind == 1);
    d_done = (kind == 0);
    if (!f_done) begin bus.if_req = 1'b1; bus.if_addr = fa; end
    if (!d_done && !late) begin
      bus.mem_req = 1'b1; bus.mem_we = we; bus.mem_addr = da; bus.mem_wdata = wd;
    end
    cyc = 0;
    while (!(f_done && d_done) && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (f_done && bus.if_req) bus.if_req = 1'b0;
      if (d_done && bus.mem_req) bus.mem_req = 1'b0;
      if (late && cyc == 1) begin
        bus.mem_req = 1'b1; bus.mem_we = we; bus.mem_addr = da; bus.mem_wdata = wd;
      end
      if (!f_done && bus.if_valid) begin
        f_done = 1'b1;
        if (!hold) bus.if_req = 1'b0;
      end
      if (!d_done && bus.mem_valid && !(late && cyc == 1)) begin
        d_done = 1'b1;
        if (!hold) bus.mem_req = 1'b0;
      end
    end
    if (!(f_done && d_done)) begin
      fail_now("round_no_completion");
      bus.if_req = 1'b0; bus.mem_req = 1'b0;
    end
    if (bus.if_req || bus.mem_req) begin
      @(negedge clk);
      bus.if_req = 1'b0; bus.mem_req = 1'b0;
    end
  endtask

  // ---------------- memory responder --------------------------------------
  initial begin
    bit   active;
    int   k;
    acc_t cur;
    active = 1'b0;
    k = 0;
    cur = '{addr: 32'h0, we: 1'b0, wdata: 32'h0, dly: 0, is_data: 1'b0};
    bus.ram_ack   = 1'b0;
    bus.ram_rdata = 32'h0;
    forever begin
      @(negedge clk);
      bus.ram_ack   = 1'b0;
      bus.ram_rdata = $urandom;
      if (rst) begin
        active = 1'b0;
      end else if (bus.ram_req) begin
        if (!active) begin
          active = 1'b1;
          k = 0;
          if (acc_q.size() == 0) begin
            fail_now("unexpected_ram_grant");
            cur = '{addr: bus.ram_addr, we: bus.ram_we, wdata: bus.ram_wdata, dly: 1, is_data: 1'b1};
          end else begin
            cur = acc_q.pop_front();
          end
        end
        check("ram_addr", bus.ram_addr, cur.addr);
        check("ram_we", {31'b0, bus.ram_we}, {31'b0, cur.we});
        if (cur.we) check("ram_wdata", bus.ram_wdata, cur.wdata);
        k++;
        if (k == cur.dly) begin
          bus.ram_ack = 1'b1;
          if (cur.we) ram_mem[cur.addr] = cur.wdata;
          else        bus.ram_rdata = ram_rd(cur.addr);
        end
      end else begin
        if (active) begin
          active = 1'b0;
          check("ram_req_cycles", k, acked(cur.dly) ? cur.dly : TO + 1);
          check("valid_after_drop", {31'b0, cur.is_data ? bus.mem_valid : bus.if_valid}, 32'd1);
        end
        // Acks with no access in flight must be ignored.
        if ($urandom_range(0, 3) == 0) bus.ram_ack = 1'b1;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------------------------
  initial begin
    logic [4:0] en_exp;
    logic       ds, fs, prev_mv, prev_iv;
    rsp_t       r;
    prev_mv = 1'b0;
    prev_iv = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst) begin
        ds = bus.mem_req & ~bus.mem_valid;
        fs = bus.if_req & ~bus.if_valid;
        en_exp = ds ? 5'b00000 : (fs ? 5'b00111 : 5'b11111);
        check("stage_enables", {27'b0, bus.pc_en, bus.IF, bus.ID, bus.EX, bus.Mem}, {27'b0, en_exp});
        if (bus.mem_valid) begin
          if (prev_mv) fail_now("mem_valid_not_pulse");
          if (exp_mem_q.size() == 0) fail_now("spurious_mem_valid");
          else begin
            r = exp_mem_q.pop_front();
            check("mem_rdata", bus.mem_rdata, r.rdata);
            if (r.to) berr_exp = 1'b1;
          end
        end
        if (bus.if_valid) begin
          if (prev_iv) fail_now("if_valid_not_pulse");
          if (exp_if_q.size() == 0) fail_now("spurious_if_valid");
          else begin
            r = exp_if_q.pop_front();
            check("if_rdata", bus.if_rdata, r.rdata);
            if (r.to) berr_exp = 1'b1;
          end
        end
        check("bus_err", {31'b0, bus.bus_err}, {31'b0, berr_exp});
      end
      prev_mv = bus.mem_valid;
      prev_iv = bus.if_valid;
    end
  end

  // ---------------- main stimulus -----------------------------------------
  initial begin
    int n;
    rst = 1'b1;
    bus.if_req = 1'b0; bus.if_addr = 32'h0;
    bus.mem_req = 1'b0; bus.mem_we = 1'b0; bus.mem_addr = 32'h0; bus.mem_wdata = 32'h0;
    last_load = 32'h0;
    berr_exp  = 1'b0;
    ref_mem[32'h0040_0000] = 32'h8C22_0004;
    ram_mem[32'h0040_0000] = 32'h8C22_0004;
    repeat (2) @(negedge clk);
    check("rst_ram_req", {31'b0, bus.ram_req}, 32'd0);
    check("rst_ram_we", {31'b0, bus.ram_we}, 32'd0);
    check("rst_ram_addr", bus.ram_addr, 32'h0);
    check("rst_ram_wdata", bus.ram_wdata, 32'h0);
    check("rst_valids", {30'b0, bus.if_valid, bus.mem_valid}, 32'd0);
    check("rst_if_rdata", bus.if_rdata, 32'h0);
    check("rst_mem_rdata", bus.mem_rdata, 32'h0);
    check("rst_bus_err", {31'b0, bus.bus_err}, 32'd0);
    check("rst_enables", {27'b0, bus.pc_en, bus.IF, bus.ID, bus.EX, bus.Mem}, 32'h1F);
    rst = 1'b0;

    run_round(0, 32'h0040_0000, 32'h0, 1'b0, 32'h0, 3, 0, 1'b0);
    run_round(2, 32'h0040_0004, 32'h1001_0000, 1'b0, 32'h0, 1, 1, 1'b0);
    run_round(1, 32'h0, 32'h1001_0008, 1'b1, 32'hDEAD_BEEF, 0, 2, 1'b0);
    run_round(1, 32'h0, 32'h1001_0000, 1'b0, 32'h0, 0, 0, 1'b0);
    run_round(1, 32'h0, 32'h1001_0008, 1'b0, 32'h0, 0, 1, 1'b1);
    run_round(3, 32'h0040_0008, 32'h1001_0004, 1'b0, 32'h0, 2, 1, 1'b0);
    run_round(1, 32'h0, 32'h1001_000C, 1'b0, 32'h0, 0, TO + 1, 1'b0);

    for (n = 0; n < 60; n++) begin
      run_round(int'($urandom_range(0, 3)),
                32'h0040_0000 + 32'(4 * $urandom_range(0, 15)),
                32'h1001_0000 + 32'(4 * $urandom_range(0, 7)),
                1'($urandom_range(0, 1)), $urandom,
                rand_dly(), rand_dly(), 1'($urandom_range(0, 1)));
    end

    repeat (3) @(negedge clk);
    check("leftover_grants", acc_q.size(), 32'd0);
    check("leftover_responses", exp_if_q.size() + exp_mem_q.size(), 32'd0);

    // Reset in the middle of a data access that is never acknowledged.
    acc_q.push_back('{addr: 32'h1001_0010, we: 1'b0, wdata: 32'h0, dly: 0, is_data: 1'b1});
    bus.mem_req = 1'b1; bus.mem_we = 1'b0; bus.mem_addr = 32'h1001_0010;
    n = 0;
    while (!bus.ram_req && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (!bus.ram_req) fail_now("mid_access_no_grant");
    @(negedge clk);
    rst = 1'b1;
    bus.mem_req = 1'b0;
    @(negedge clk);
    #1;
    check("midrst_ram_req", {31'b0, bus.ram_req}, 32'd0);
    check("midrst_mem_valid", {31'b0, bus.mem_valid}, 32'd0);
    check("midrst_bus_err", {31'b0, bus.bus_err}, 32'd0);
    check("midrst_enables", {27'b0, bus.pc_en, bus.IF, bus.ID, bus.EX, bus.Mem}, 32'h1F);
    @(negedge clk);
    acc_q.delete();
    exp_if_q.delete();
    exp_mem_q.delete();
    berr_exp  = 1'b0;
    last_load = 32'h0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("postrst_ram_req", {31'b0, bus.ram_req}, 32'd0);
    check("postrst_mem_rdata", bus.mem_rdata, 32'h0);
    check("postrst_bus_err", {31'b0, bus.bus_err}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout at %0t", $time);
    $fatal(1, "simulation time limit");
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single-ported unified memory between the instruction-fetch stage and the Mem stage of the 5-stage MIPS pipeline. It sequences each access through a request/acknowledge handshake with variable memory latency. It drives the same per-stage enable set as the load-use stall logic (pc_en, IF, ID, EX, Mem); the pipeline top ANDs the two sets together. Data accesses take priority over fetches, because the Mem-stage instruction is older.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 255, max cycles waiting for ram_ack before abort (1..255)

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- if_req  in  1  fetch request, held until if_valid
- if_addr  in  ADDR_W  fetch address
- if_rdata  out  DATA_W  fetched instruction, valid with if_valid
- if_valid  out  1  one-cycle completion pulse for fetch
- mem_req  in  1  load/store request, held until mem_valid
- mem_we  in  1  1 = store
- mem_addr  in  ADDR_W  data address
- mem_wdata  in  DATA_W  store data
- mem_rdata  out  DATA_W  load data, valid with mem_valid
- mem_valid  out  1  one-cycle completion pulse for data access
- ram_req  out  1  memory request, held until ram_ack or timeout
- ram_we  out  1  memory write strobe
- ram_addr  out  ADDR_W  memory address
- ram_wdata  out  DATA_W  memory write data
- ram_rdata  in  DATA_W  memory read data, valid with ram_ack
- ram_ack  in  1  memory completion, one cycle
- bus_err  out  1  sticky timeout flag, cleared only by rst
- pc_en, IF, ID, EX, Mem  out  1 each  stage enables, 1 = advance

## Operation
- FSM states: IDLE, D_ACC, I_ACC, DONE. Reset state IDLE.
- IDLE, mem_req=1: latch mem_addr, mem_we, mem_wdata into ram_addr, ram_we, ram_wdata. Set ram_req<=1. Go to D_ACC.
- IDLE, mem_req=0, if_req=1: latch if_addr, ram_we<=0, ram_req<=1. Go to I_ACC.
- IDLE, both requests 0: stay in IDLE.
- D_ACC/I_ACC, ram_ack=1:
  - ram_req<=0 and ram_we<=0.
  - Capture ram_rdata into mem_rdata (D_ACC with a load only) or into if_rdata (I_ACC).
  - Set the matching valid<=1. Go to DONE.
- D_ACC/I_ACC, no ack: increment wait counter (8-bit, cleared on every grant).
- Timeout: wait counter == TIMEOUT with no ack.
  - ram_req<=0 and bus_err<=1.
  - Complete as if acked, with rdata = 0.
  - Go to DONE.
- DONE: the valid pulse is high this cycle; grant nothing; next state IDLE. This stops the still-held request from being re-granted.
- mem_rdata and if_rdata hold their value until the next capture. Stores leave mem_rdata unchanged.
- The ram_* outputs are registered and stay stable for the whole request.
- ram_ack outside D_ACC/I_ACC is ignored.

## Timing
- Reset values: all outputs 0, except pc_en, IF, ID, EX, Mem, which are 1.
- Stage enables are combinational:
  - data_stall = mem_req & ~mem_valid → pc_en, IF, ID, EX, Mem all 0.
  - Else fetch_stall = if_req & ~if_valid → pc_en=0, IF=0; ID, EX, Mem = 1.
  - Else all 1.
- Latency:
  - Request sampled in IDLE at cycle t; ram_req=1 from t+1.
  - ram_ack at cycle t+k (k≥1) → valid=1 at t+k+1.
  - Minimum completion is 2 cycles; back-to-back accesses cost 3 cycles each.
- Simultaneous if_req and mem_req in IDLE: data granted first. The fetch is granted in the first IDLE after that DONE, if if_req is still held.
- A new mem_req arriving during I_ACC waits for the fetch to complete. It is not preemptive.
- rst mid-access: next cycle state IDLE, ram_req=0, no valid pulse, bus_err=0. The requester re-issues.

## Test plan
- Reset: hold rst 2 cycles during D_ACC → ram_req=0, mem_valid=0, bus_err=0, all enables 1 next cycle.
- Fetch only:
  - if_req, if_addr=0x00400000; ram_ack 3 cycles after ram_req with ram_rdata=0x8C220004.
  - Required: if_valid one cycle later with if_rdata=0x8C220004.
  - pc_en=IF=0 until that cycle, ID/EX/Mem=1 throughout.
- Simultaneous requests:
  - if_req and mem_req (load 0x10010000) in the same cycle; memory acks after 1 cycle each.
  - Required: data access first (ram_addr=0x10010000), then fetch; all enables 0 until mem_valid.
- Store:
  - mem_we=1, mem_addr=0x10010008, mem_wdata=0xDEADBEEF.
  - Required: ram_we=1 with that addr/data while ram_req=1; mem_valid pulses; mem_rdata unchanged.
- Timeout: TIMEOUT=4, never ack → ram_req drops after 4 wait cycles, bus_err=1 and sticky, mem_valid pulses with mem_rdata=0.
- No re-grant: ram_ack on the first cycle, requester holds mem_req through mem_valid → exactly one ram_req burst; IDLE is entered only after DONE.
